// File: rtl/seq_stage_sequencer_if.sv
// seq_stage_sequencer_if: control/status bundle between the SEQ core datapath and its stage sequencer
interface seq_stage_sequencer_if #(parameter int CNT_W = 32);
  logic start;
  logic [3:0] icode;
  logic instr_valid;
  logic imem_error;
  logic mem_ready;
  logic stall_req;
  logic en_fetch;
  logic en_decode;
  logic en_execute;
  logic en_memory;
  logic en_writeback;
  logic en_pc;
  logic mem_req;
  logic [2:0] stat;
  logic busy;
  logic [CNT_W-1:0] instr_count;
  logic [CNT_W-1:0] cycle_count;
  modport master (
    output start, icode, instr_valid, imem_error, mem_ready, stall_req,
    input en_fetch, en_decode, en_execute, en_memory, en_writeback, en_pc,
    input mem_req, stat, busy, instr_count, cycle_count
  );
  modport slave (
    input start, icode, instr_valid, imem_error, mem_ready, stall_req,
    output en_fetch, en_decode, en_execute, en_memory, en_writeback, en_pc,
    output mem_req, stat, busy, instr_count, cycle_count
  );
endinterface

// File: rtl/seq_stage_sequencer.sv
// seq_stage_sequencer: multi-cycle stage sequencer for the SEQ Y86-64 core
module seq_stage_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst,
  seq_stage_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALTED} state_t;
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  state_t state;
  logic [3:0] icode_q;
  logic [WW-1:0] wait_cnt;
  logic [2:0] stat;
  logic [CNT_W-1:0] instr_count;
  logic [CNT_W-1:0] cycle_count;
  logic mem_op;
  logic mem_wait;
  logic busy;
  logic stall;
  logic retire;
  assign mem_op = icode_q inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  assign mem_wait = state == MEMORY && mem_op;
  assign busy = state != IDLE && state != HALTED;
  assign stall = bus.stall_req && !mem_wait;
  assign retire = !stall && (state == PCUPD ||
                  (state == FETCH && !bus.imem_error && bus.icode == 4'h0));
  assign bus.en_fetch = state == FETCH && !stall;
  assign bus.en_decode = state == DECODE && !stall;
  assign bus.en_execute = state == EXECUTE && !stall;
  assign bus.en_memory = state == MEMORY && (mem_op ? bus.mem_ready : !stall);
  assign bus.en_writeback = state == WRITEBACK && !stall;
  assign bus.en_pc = state == PCUPD && !stall;
  assign bus.mem_req = mem_wait;
  assign bus.busy = busy;
  assign bus.stat = stat;
  assign bus.instr_count = instr_count;
  assign bus.cycle_count = cycle_count;
  // stage stepping, memory wait timeout, status and saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      stat <= 3'd1;
      icode_q <= 4'h0;
      wait_cnt <= '0;
      instr_count <= '0;
      cycle_count <= '0;
    end else begin
      if (busy && cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
      if (retire && instr_count != '1) instr_count <= instr_count + CNT_W'(1);
      case (state)
        IDLE: if (bus.start) state <= FETCH;
        FETCH: if (!stall) begin
          icode_q <= bus.icode;
          if (bus.imem_error) begin
            stat <= 3'd3;
            state <= HALTED;
          end else if (bus.icode == 4'h0) begin
            stat <= 3'd2;
            state <= HALTED;
          end else if (!bus.instr_valid || bus.icode > 4'hB) begin
            stat <= 3'd4;
            state <= HALTED;
          end else state <= DECODE;
        end
        DECODE: if (!stall) state <= EXECUTE;
        EXECUTE: if (!stall) begin
          wait_cnt <= '0;
          state <= MEMORY;
        end
        MEMORY: if (mem_op) begin
          if (bus.mem_ready) state <= WRITEBACK;
          else if (wait_cnt == WW'(MEM_TIMEOUT - 1)) begin
            stat <= 3'd3;
            state <= HALTED;
          end else wait_cnt <= wait_cnt + WW'(1);
        end else if (!stall) state <= WRITEBACK;
        WRITEBACK: if (!stall) state <= PCUPD;
        PCUPD: if (!stall) state <= FETCH;
        default: state <= state;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_stage_sequencer.sv
// tb_seq_stage_sequencer: scoreboard bench for the SEQ stage sequencer
module tb_seq_stage_sequencer;
  localparam int CW = 4;
  localparam logic [6:0] F = 7'b1000000, D = 7'b0100000, E = 7'b0010000, M = 7'b0001000;
  localparam logic [6:0] W = 7'b0000100, P = 7'b0000010, R = 7'b0000001;
  typedef struct packed {logic [31:0] rel; logic [6:0] ev;} exp_t;
  logic clk = 0;
  logic rst = 1;
  int cyc = 0;
  int t0 = 0;
  int tests = 0;
  int fails = 0;
  exp_t q[$];
  exp_t e;
  logic [6:0] ev;
  seq_stage_sequencer_if #(.CNT_W(CW)) bif();
  seq_stage_sequencer #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bif));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign ev = {bif.en_fetch, bif.en_decode, bif.en_execute, bif.en_memory,
               bif.en_writeback, bif.en_pc, bif.mem_req};
  always @(negedge clk) begin
    if (ev != 7'b0) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL event_unexpected rel=%0d got=%b required=none", cyc - t0, ev);
      end else begin
        e = q.pop_front();
        if (e.rel != 32'(cyc - t0) || e.ev != ev) begin
          fails++;
          $display("FAIL event rel=%0d got=%b required rel=%0d ev=%b", cyc - t0, ev, e.rel, e.ev);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s got=%0d required=%0d", name, act, req);
    end
  endtask
  task automatic push(input int rel, input logic [6:0] v);
    q.push_back('{rel: 32'(rel), ev: v});
  endtask
  task automatic step_to(input int n);
    while (cyc - t0 < n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic check_at(input int n);
    step_to(n);
    @(negedge clk);
  endtask
  task automatic go(input logic [3:0] ic, input logic v);
    @(posedge clk);
    #1;
    bif.icode = ic;
    bif.instr_valid = v;
    bif.start = 1;
    t0 = cyc;
    @(posedge clk);
    #1;
    bif.start = 0;
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1;
    bif.start = 0;
    bif.icode = 0;
    bif.instr_valid = 0;
    bif.imem_error = 0;
    bif.mem_ready = 0;
    bif.stall_req = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    check("queue_drained", q.size(), 0);
    q.delete();
  endtask
  initial begin
    do_reset();
    @(negedge clk);
    check("rst_stat", bif.stat, 1);
    check("rst_busy", bif.busy, 0);
    check("rst_instr", bif.instr_count, 0);
    check("rst_cycle", bif.cycle_count, 0);
    check("rst_outs", ev, 0);
    // plain instruction, back-to-back refetch then halt
    push(1, F); push(2, D); push(3, E); push(4, M); push(5, W); push(6, P); push(7, F);
    go(4'h1, 1);
    step_to(3);
    bif.icode = 4'h0;
    check_at(7);
    check("t1_instr_after_pc", bif.instr_count, 1);
    check_at(8);
    check("t1_stat", bif.stat, 2);
    check("t1_busy", bif.busy, 0);
    check("t1_instr", bif.instr_count, 2);
    check("t1_cycle", bif.cycle_count, 7);
    do_reset();
    // memory instruction, ready on the third request cycle; early stray ready ignored
    push(1, F); push(2, D); push(3, E); push(4, R); push(5, R); push(6, M | R);
    push(7, W); push(8, P); push(9, F);
    go(4'h5, 1);
    step_to(2);
    bif.mem_ready = 1;
    step_to(3);
    bif.mem_ready = 0;
    bif.icode = 4'h0;
    step_to(6);
    bif.mem_ready = 1;
    step_to(7);
    bif.mem_ready = 0;
    check_at(9);
    check("t2_cycle", bif.cycle_count, 8);
    check("t2_instr", bif.instr_count, 1);
    check_at(10);
    check("t2_stat", bif.stat, 2);
    do_reset();
    // halt, then start ignored
    push(1, F);
    go(4'h0, 1);
    check_at(2);
    check("t3_stat", bif.stat, 2);
    check("t3_instr", bif.instr_count, 1);
    check("t3_busy", bif.busy, 0);
    step_to(3);
    bif.start = 1;
    step_to(4);
    bif.start = 0;
    check_at(6);
    check("t3_stat_hold", bif.stat, 2);
    check("t3_busy_hold", bif.busy, 0);
    check("t3_cycle_hold", bif.cycle_count, 1);
    do_reset();
    // illegal icode, address error priority, invalid flag
    push(1, F);
    go(4'hC, 1);
    check_at(2);
    check("t4_ins_stat", bif.stat, 4);
    check("t4_ins_instr", bif.instr_count, 0);
    do_reset();
    push(1, F);
    bif.imem_error = 1;
    go(4'h0, 1);
    check_at(2);
    check("t4_adr_stat", bif.stat, 3);
    check("t4_adr_instr", bif.instr_count, 0);
    do_reset();
    push(1, F);
    go(4'h1, 0);
    check_at(2);
    check("t4_invalid_stat", bif.stat, 4);
    do_reset();
    // memory timeout
    push(1, F); push(2, D); push(3, E); push(4, R); push(5, R); push(6, R); push(7, R);
    go(4'hA, 1);
    check_at(8);
    check("t5_stat", bif.stat, 3);
    check("t5_busy", bif.busy, 0);
    check("t5_mem_req", bif.mem_req, 0);
    check_at(10);
    check("t5_stat_hold", bif.stat, 3);
    do_reset();
    // stall in decode
    push(1, F); push(4, D); push(5, E); push(6, M); push(7, W); push(8, P); push(9, F);
    go(4'h2, 1);
    step_to(2);
    bif.stall_req = 1;
    step_to(4);
    bif.stall_req = 0;
    bif.icode = 4'h0;
    check_at(9);
    check("t6_cycle", bif.cycle_count, 8);
    check_at(10);
    check("t6_stat", bif.stat, 2);
    do_reset();
    // stall ignored during a pending request, then reset mid-wait
    push(1, F); push(2, D); push(3, E); push(4, R); push(5, R);
    go(4'h4, 1);
    step_to(4);
    bif.stall_req = 1;
    step_to(5);
    rst = 1;
    step_to(6);
    rst = 0;
    bif.stall_req = 0;
    @(negedge clk);
    check("t6_rst_mem_req", bif.mem_req, 0);
    check("t6_rst_busy", bif.busy, 0);
    check("t6_rst_stat", bif.stat, 1);
    check("t6_rst_instr", bif.instr_count, 0);
    check("t6_rst_cycle", bif.cycle_count, 0);
    do_reset();
    // counter saturation over a long run
    for (int i = 0; i < 17; i++) begin
      push(6 * i + 1, F); push(6 * i + 2, D); push(6 * i + 3, E);
      push(6 * i + 4, M); push(6 * i + 5, W); push(6 * i + 6, P);
    end
    push(103, F);
    go(4'h1, 1);
    check_at(16);
    check("t7_cycle_at_max", bif.cycle_count, 15);
    check_at(17);
    check("t7_cycle_sat", bif.cycle_count, 15);
    step_to(100);
    bif.icode = 4'h0;
    check_at(104);
    check("t7_instr_sat", bif.instr_count, 15);
    check("t7_cycle_end", bif.cycle_count, 15);
    check("t7_stat", bif.stat, 2);
    do_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
